hex_entry_encoder: RTL and testbench
====================================

# hex_entry_encoder

- Converts operator push-button input into an 8-bit binary byte; it is the input-side counterpart of the DIP-switch-to-seven-segment display path.
- Debounces four board buttons and edits the high or low hex nibble of a working byte.
- Commits that byte on request and presents it on a valid/ready output port for downstream logic.
- `value` and `selectHigh` feed the seven-segment display path so the operator sees the byte being entered.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive stable samples needed to accept a button level change; legal range 2 to 2^20-1.
- cmosClock  input  1  system clock; all state is updated on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- pushButton  input  4  raw, asynchronous, active-low buttons:
  - [0] increment the selected nibble
  - [1] decrement the selected nibble
  - [2] toggle which nibble is selected
  - [3] commit the working byte
- dataReady  input  1  downstream accepts `dataOut` when high at a clock edge while `dataValid` is high.
- value  output  8  working byte being edited (registered).
- selectHigh  output  1  nibble select: 1 = bits [7:4] selected, 0 = bits [3:0] selected (registered).
- dataOut  output  8  committed byte (registered).
- dataValid  output  1  committed byte pending (registered).

## Operation
- **Reset.** While resetN=0, without waiting for a clock edge:
  - value=0x00, selectHigh=0, dataOut=0x00, dataValid=0.
  - Every debounced button state = released; all debounce counters = 0; FSM = EDIT.
- **Synchronizer.** Each button passes through a two-flop synchronizer, then an inverter, giving pressed=1.
- **Debounce (per button).**
  - The counter increments each cycle the synchronized level differs from the stable level.
  - The counter clears to 0 on any cycle the two levels match, so bounces shorter than DEBOUNCE_CYCLES are rejected.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the stable level flips on the next edge and the counter clears.
- **Press event.**
  - A registered one-cycle pulse, asserted on the cycle after the stable level goes released→pressed.
  - Releases generate no event.
  - Holding a button produces exactly one event; there is no auto-repeat.
- **Edits.** Each edit is applied on the edge that samples the event pulse.
  - Increment: selected nibble = (nibble+1) mod 16. 0xF wraps to 0x0 with no carry into the other nibble.
  - Decrement: selected nibble = (nibble-1) mod 16. 0x0 wraps to 0xF with no borrow.
  - Increment and decrement in the same cycle: no change.
  - Toggle: selectHigh inverts. If toggle coincides with increment or decrement, the edit applies to the nibble selected before the toggle.
- **FSM.**
  - EDIT:
    - On a commit event: dataOut←value, dataValid←1, go to PENDING.
    - If an edit event coincides with commit, dataOut captures the pre-edit value.
  - PENDING:
    - dataOut and dataValid are held.
    - Edits to value and selectHigh continue normally.
    - Commit events are dropped, not queued.
    - dataReady=1 at an edge: dataValid←0, go to EDIT.
    - A commit event in the same cycle as dataReady=1 is dropped.
- dataReady is ignored while in EDIT.
- **Reset mid-operation:** a pending byte is discarded, a partial debounce count is discarded, and a button held through reset release must re-qualify for a full DEBOUNCE_CYCLES before it generates an event.

## Timing
- Latency from a raw press to its effect, for a press held stable, counted in edges from the first edge that samples the pressed level:
  - 2 synchronizer stages
  - DEBOUNCE_CYCLES debounce
  - 1 event register
  - 1 apply
  - Total: value or selectHigh changes DEBOUNCE_CYCLES+4 edges after the first sampling edge.
- Commit latency is identical to edit latency: dataValid rises DEBOUNCE_CYCLES+4 edges after the first sampling edge.
- The handshake completes on the edge where dataValid=1 and dataReady=1; dataValid is 0 in the following cycle. Back-to-back transfers are limited by debounce rate, not by the handshake.
- Release latency, relevant before the same button can be pressed again: DEBOUNCE_CYCLES+2 edges.
- All outputs are glitch-free registers with no combinational path from inputs.

## Test plan
- **Reset then increment.** DEBOUNCE_CYCLES=4; reset, then hold pushButton[0]=0 for 20 cycles → value=0x01 exactly 8 edges after the first sampling edge. A second press from 0x0F gives 0x00, and the upper nibble is unchanged.
- **Bounce rejection.** Toggle pushButton[0] every 2 cycles for 30 cycles, then release → value unchanged at 0x00.
- **Nibble select and decrement.**
  - toggle → selectHigh=1
  - decrement → value=0xF0
  - toggle → selectHigh=0
  - increment ×3 → value=0xF3
- **Commit handshake.** value=0xA5, dataReady=0; commit → dataValid=1, dataOut=0xA5. Then:
  - increment → value=0xA6, dataOut still 0xA5
  - second commit → dropped
  - dataReady=1 for one cycle → dataValid=0 on the next cycle
  - new commit → dataOut=0xA6
- **Simultaneous events.** Press [0] and [1] together → no change. Press [2] and [0] together with value=0x00, selectHigh=0 → value=0x01, selectHigh=1.
- **Reset mid-operation.** Assert resetN=0 asynchronously while in PENDING (dataOut=0x3C) and mid-debounce → all outputs zero immediately. A button held through reset release produces its event only after a full debounce period (DEBOUNCE_CYCLES+4 edges).

Source files
------------

// File: rtl/hex_entry_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hex_entry_encoder
//  Description : Debounced four-button hex byte editor with a committed-byte
//                valid/ready output port.
//  Revision    : 1.0 - initial release
// ============================================================================

module hex_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       cmosClock,
    input  logic       resetN,
    input  logic [3:0] pushButton,
    input  logic       dataReady,
    output logic [7:0] value,
    output logic       selectHigh,
    output logic [7:0] dataOut,
    output logic       dataValid
);

    localparam int                 c_CNT_W    = 20;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_EDIT    = 1'b0,
        ST_PENDING = 1'b1
    } stateT;

    logic [3:0] r_syncMeta;
    logic [3:0] r_syncRaw;
    logic [3:0] w_syncPressed;
    logic [3:0] w_stable;
    logic [3:0] r_stableDly;
    logic [3:0] r_event;

    logic [7:0] r_value;
    logic       r_selectHigh;
    logic [7:0] r_dataOut;
    logic       r_dataValid;

    logic       w_inc;
    logic       w_dec;
    logic [3:0] w_nibble;
    logic [3:0] w_nibbleNext;
    logic [7:0] w_valueNext;

    stateT      r_state;
    stateT      w_stateNext;
    logic       w_capture;
    logic       w_release;

    // Raw buttons idle high, so the synchronizer resets to the released level.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            r_syncMeta <= 4'hF;
            r_syncRaw  <= 4'hF;
        end else begin
            r_syncMeta <= pushButton;
            r_syncRaw  <= r_syncMeta;
        end
    end

    assign w_syncPressed = ~r_syncRaw;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_debounce
            logic [c_CNT_W-1:0] r_count;
            logic               r_stable;

            always_ff @(posedge cmosClock or negedge resetN) begin
                if (!resetN) begin
                    r_count  <= '0;
                    r_stable <= 1'b0;
                end else if (w_syncPressed[g] != r_stable) begin
                    if (r_count == c_CNT_LAST) begin
                        r_stable <= w_syncPressed[g];
                        r_count  <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    r_count <= '0;
                end
            end

            assign w_stable[g] = r_stable;
        end
    endgenerate

    // Rising edge of the stable level gives one event per press, none on release.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            r_stableDly <= 4'h0;
            r_event     <= 4'h0;
        end else begin
            r_stableDly <= w_stable;
            r_event     <= w_stable & ~r_stableDly;
        end
    end

    assign w_inc = r_event[0] & ~r_event[1];
    assign w_dec = r_event[1] & ~r_event[0];

    // Edits target the nibble selected before any coincident toggle.
    always_comb begin
        w_nibble     = r_selectHigh ? r_value[7:4] : r_value[3:0];
        w_nibbleNext = w_nibble;
        if (w_inc) begin
            w_nibbleNext = w_nibble + 4'd1;
        end else if (w_dec) begin
            w_nibbleNext = w_nibble - 4'd1;
        end
        w_valueNext = r_selectHigh ? {w_nibbleNext, r_value[3:0]}
                                   : {r_value[7:4], w_nibbleNext};
    end

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            r_value      <= 8'h00;
            r_selectHigh <= 1'b0;
        end else begin
            r_value      <= w_valueNext;
            r_selectHigh <= r_selectHigh ^ r_event[2];
        end
    end

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_EDIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_EDIT: begin
                if (r_event[3]) begin
                    w_capture   = 1'b1;
                    w_stateNext = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (dataReady) begin
                    w_release   = 1'b1;
                    w_stateNext = ST_EDIT;
                end
            end
            default: begin
                w_stateNext = ST_EDIT;
            end
        endcase
    end

    // Capture uses the current value, so a coincident edit is not included.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            r_dataOut   <= 8'h00;
            r_dataValid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_dataOut   <= r_value;
                r_dataValid <= 1'b1;
            end else if (w_release) begin
                r_dataValid <= 1'b0;
            end
        end
    end

    assign value      = r_value;
    assign selectHigh = r_selectHigh;
    assign dataOut    = r_dataOut;
    assign dataValid  = r_dataValid;

endmodule

`default_nettype wire

// File: tb/tb_hex_entry_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_entry_encoder
//  Description : Self-checking bench for hex_entry_encoder against a byte-level
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_hex_entry_encoder;

    localparam int DEB  = 4;
    localparam int HOLD = DEB + 6;

    logic       cmosClock = 1'b0;
    logic       resetN;
    logic [3:0] pushButton;
    logic       dataReady;
    logic [7:0] value;
    logic       selectHigh;
    logic [7:0] dataOut;
    logic       dataValid;

    int nCompared = 0;
    int nFailed   = 0;

    // Reference model state
    int mValue;
    int mSel;
    int mOut;
    int mPending;

    hex_entry_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .cmosClock (cmosClock),
        .resetN    (resetN),
        .pushButton(pushButton),
        .dataReady (dataReady),
        .value     (value),
        .selectHigh(selectHigh),
        .dataOut   (dataOut),
        .dataValid (dataValid)
    );

    always #5 cmosClock = ~cmosClock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".value"},      value,                 8'(mValue));
        check({tag, ".selectHigh"}, {7'd0, selectHigh},    8'(mSel));
        check({tag, ".dataOut"},    dataOut,               8'(mOut));
        check({tag, ".dataValid"},  {7'd0, dataValid},     8'(mPending));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge cmosClock);
        #1;
    endtask

    task automatic modelReset();
        mValue = 0; mSel = 0; mOut = 0; mPending = 0;
    endtask

    // Byte-level effect of one clean press of the buttons in mask.
    task automatic modelPress(input logic [3:0] mask);
        int pre;
        int sh;
        int nib;
        pre = mValue;
        if (mask[0] != mask[1]) begin
            sh  = (mSel != 0) ? 4 : 0;
            nib = (mValue >> sh) % 16;
            nib = mask[0] ? (nib + 1) % 16 : (nib + 15) % 16;
            mValue = (mValue & ~(15 << sh)) | (nib << sh);
        end
        if (mask[2]) mSel = 1 - mSel;
        if (mask[3] && mPending == 0) begin
            mOut     = pre;
            mPending = 1;
        end
    endtask

    task automatic press(input logic [3:0] mask, input string tag);
        pushButton = ~mask;
        tick(HOLD);
        pushButton = 4'hF;
        tick(HOLD);
        modelPress(mask);
        checkAll(tag);
    endtask

    task automatic handshake(input string tag);
        dataReady = 1'b1;
        tick(1);
        dataReady = 1'b0;
        mPending  = 0;
        checkAll(tag);
    endtask

    task automatic setValue(input int target);
        int want;
        for (int half = 1; half >= 0; half--) begin
            if (mSel != half) press(4'b0100, "set.sel");
            want = (target >> (4 * half)) % 16;
            while (((mValue >> (4 * half)) % 16) != want) press(4'b0001, "set.inc");
        end
    endtask

    initial begin
        resetN     = 1'b0;
        pushButton = 4'hF;
        dataReady  = 1'b0;
        modelReset();
        tick(3);
        checkAll("reset");
        resetN = 1'b1;

        // Exact press-to-effect latency: DEB+4 edges from first sampling edge.
        pushButton = 4'b1110;
        tick(DEB + 3);
        check("lat.before", value, 8'h00);
        tick(1);
        check("lat.after", value, 8'h01);
        tick(20 - (DEB + 4));
        pushButton = 4'hF;
        tick(HOLD);
        mValue = 1;
        checkAll("lat.hold");

        // Low nibble wrap without carry.
        press(4'b0010, "dec1");
        press(4'b0010, "dec2");
        check("wrap.pre", value, 8'h0F);
        press(4'b0001, "wrapInc");
        check("wrap.post", value, 8'h00);

        // Bounces shorter than the debounce window are ignored.
        for (int i = 0; i < 15; i++) begin
            pushButton[0] = ~pushButton[0];
            tick(2);
        end
        pushButton = 4'hF;
        tick(HOLD);
        checkAll("bounce");

        press(4'b0100, "tgl1");
        press(4'b0010, "decHi");
        check("decHi.val", value, 8'hF0);
        press(4'b0100, "tgl2");
        for (int i = 0; i < 3; i++) press(4'b0001, "inc3");
        check("F3", value, 8'hF3);

        // Commit handshake.
        setValue(8'hA5);
        check("A5", value, 8'hA5);
        press(4'b1000, "commit1");
        check("commit1.out", dataOut, 8'hA5);
        press(4'b0001, "incPend");
        check("incPend.out", dataOut, 8'hA5);
        press(4'b1000, "commitDrop");
        handshake("hs1");
        check("hs1.valid", {7'd0, dataValid}, 8'h00);
        press(4'b1000, "commit2");
        check("commit2.out", dataOut, 8'hA6);
        handshake("hs2");

        // Simultaneous events.
        setValue(8'h00);
        if (mSel != 0) press(4'b0100, "selLow");
        press(4'b0011, "incDec");
        press(4'b0101, "tglInc");
        check("tglInc.val", value, 8'h01);
        check("tglInc.sel", {7'd0, selectHigh}, 8'h01);

        // Commit coinciding with an edit captures the pre-edit byte.
        press(4'b1001, "commitEdit");
        handshake("hs3");

        // Randomized button combinations and handshakes.
        for (int i = 0; i < 20; i++) begin
            press(4'($urandom_range(1, 15)), "rand");
            if ($urandom_range(0, 1) == 1) handshake("randHs");
        end

        // Reset in PENDING while a button is mid-debounce.
        if (mPending != 0) handshake("preHs");
        setValue(8'h3C);
        press(4'b1000, "commit3C");
        check("commit3C.out", dataOut, 8'h3C);
        pushButton = 4'b1101;
        tick(3);
        #3;
        resetN = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        tick(2);
        resetN = 1'b1;
        tick(DEB + 3);
        check("rq.before", value, 8'h00);
        tick(1);
        check("rq.after", value, 8'h0F);
        pushButton = 4'hF;
        tick(HOLD);
        mValue = 8'h0F;
        checkAll("rq.final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
